// File: rtl/data_memory_pkg.sv
// Shared encodings for the handshake data memory: access sizes, FSM states
// and fault-reason bits.
package data_memory_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef logic [2:0] fault_reason_t;

    localparam fault_reason_t FR_NONE  = 3'b000;
    localparam fault_reason_t FR_SIZE  = 3'b001;
    localparam fault_reason_t FR_ALIGN = 3'b010;
    localparam fault_reason_t FR_RANGE = 3'b100;

    function automatic fault_reason_t decode_fault(input logic [1:0] size,
                                                   input logic [1:0] offset,
                                                   input logic       out_of_range);
        fault_reason_t r;
        r = FR_NONE;
        case (size_e'(size))
            SZ_ILLEGAL: r = r | FR_SIZE;
            SZ_HALF:    if (offset[0]) r = r | FR_ALIGN;
            SZ_WORD:    if (offset != 2'b00) r = r | FR_ALIGN;
            default:    ;
        endcase
        if (out_of_range) r = r | FR_RANGE;
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: write enables / replicated write data for a store, and
// lane extraction plus sign/zero extension for a response.
module mem_lane_unit
    import data_memory_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        data_unsigned,
    input  logic [31:0] wd,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wd_lanes,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be       = 4'b0000;
        wd_lanes = 32'h0;
        rdata    = 32'h0;
        byte_v   = word[{offset, 3'b000} +: 8];
        half_v   = offset[1] ? word[31:16] : word[15:0];
        case (size_e'(size))
            SZ_BYTE: begin
                be       = 4'b0001 << offset;
                wd_lanes = {4{wd[7:0]}};
                rdata    = {{24{~data_unsigned & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be       = offset[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wd[15:0]}};
                rdata    = {{16{~data_unsigned & half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                be       = 4'b1111;
                wd_lanes = wd;
                rdata    = word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// Valid/ready data memory: one request outstanding, configurable wait states,
// byte/half/word access with alignment and range faults.
module data_memory_hs
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [1:0]  data_size,
    input  logic        we,
    input  logic        data_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rd,
    output logic        fault
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [3:0][7:0] mem [DEPTH_WORDS];
    logic [31:0]     word_q;

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             fault_q, fault_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      rd_last_q, rd_last_d;

    logic             accept;
    logic             sel_live;
    logic             out_of_range;
    fault_reason_t    reasons;
    logic             req_fault;
    logic             mem_we;
    logic [IDX_W-1:0] idx_live;
    logic [1:0]       lane_off;
    logic [1:0]       lane_size;
    logic [3:0]       be;
    logic [31:0]      wd_lanes;
    logic [31:0]      lane_rdata;
    logic [31:0]      rsp_rd;

    assign accept       = req_valid & req_ready;
    assign idx_live     = a[IDX_W+1:2];
    assign out_of_range = ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    assign reasons      = decode_fault(data_size, a[1:0], out_of_range);
    assign req_fault    = |reasons;
    assign mem_we       = accept & we & ~req_fault;

    // The lane unit steers live inputs while a request can be accepted and the
    // captured request for the rest of the transaction.
    assign sel_live  = (state_q == ST_IDLE) & ~acc_q;
    assign lane_off  = sel_live ? a[1:0]    : off_q;
    assign lane_size = sel_live ? data_size : size_q;
    assign rsp_rd    = fault_q ? 32'h0 : lane_rdata;

    mem_lane_unit u_lane (
        .offset        (lane_off),
        .size          (lane_size),
        .data_unsigned (uns_q),
        .wd            (wd),
        .word          (word_q),
        .be            (be),
        .wd_lanes      (wd_lanes),
        .rdata         (lane_rdata)
    );

    // Store commits on the accepting edge; the word is read back one edge
    // later so a store response naturally reflects the written lanes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_live][i] <= wd_lanes[8*i +: 8];
            end
        end
        if (acc_q) word_q <= mem[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= 1'b0;
            wait_cnt_q <= 4'd0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            fault_q    <= 1'b0;
            idx_q      <= '0;
            rd_last_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wait_cnt_q <= wait_cnt_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            fault_q    <= fault_d;
            idx_q      <= idx_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        wait_cnt_d = wait_cnt_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        fault_d    = fault_q;
        idx_d      = idx_q;
        rd_last_d  = rd_last_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_q) begin
                    acc_d      = 1'b0;
                    wait_cnt_d = 4'd0;
                    state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end else if (accept) begin
                    acc_d   = 1'b1;
                    off_d   = a[1:0];
                    size_d  = data_size;
                    uns_d   = data_unsigned;
                    fault_d = req_fault;
                    idx_d   = idx_live;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rd_last_d = rsp_rd;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) & ~acc_q & ~rst;
        rsp_valid = (state_q == ST_RESP);
        fault     = rsp_valid & fault_q;
        rd        = rsp_valid ? rsp_rd : rd_last_q;
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed vector table, handshake/reset sequences,
// randomized traffic against a byte-array reference model, and a zero-wait build.
module tb_data_memory_hs;

    localparam int DEPTH  = 256;
    localparam int DEPTH0 = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid, req_ready, we, data_unsigned, rsp_valid, rsp_ready, fault;
    logic [31:0] a, wd, rd;
    logic [1:0]  data_size;

    logic        req_valid0, req_ready0, we0, data_unsigned0, rsp_valid0, rsp_ready0, fault0;
    logic [31:0] a0, wd0, rd0;
    logic [1:0]  data_size0;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    data_memory_hs #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .wd(wd), .data_size(data_size), .we(we), .data_unsigned(data_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rd(rd), .fault(fault)
    );

    data_memory_hs #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .a(a0), .wd(wd0), .data_size(data_size0), .we(we0), .data_unsigned(data_unsigned0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rd(rd0), .fault(fault0)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        we;
        logic        uns;
        logic [31:0] exp_rd;
        logic        exp_f;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: byte-addressed little-endian memory, size in bytes.
    function automatic void model(input logic [31:0] ad, input logic [31:0] wdat,
                                  input logic [1:0] sz, input logic w, input logic u,
                                  output logic [31:0] r, output logic f);
        int n;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        f = (n == 0) || (ad % n != 0) || (ad / 4 >= DEPTH);
        r = 32'h0;
        if (f) return;
        if (w) for (int i = 0; i < n; i++) ref_mem[ad + i] = wdat[8*i +: 8];
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ad + i]) << (8*i));
        if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        r = v;
    endfunction

    task automatic txn(input logic [31:0] a_i, input logic [31:0] wd_i, input logic [1:0] sz,
                       input logic we_i, input logic uns_i, input int hold,
                       output logic [31:0] rd_o, output logic f_o, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        a = a_i; wd = wd_i; data_size = sz; we = we_i; data_unsigned = uns_i;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = $urandom; wd = $urandom; data_size = 2'($urandom); we = 1'($urandom);
        data_unsigned = 1'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd_o = rd;
        f_o  = fault;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; we = 1'b1; a = 32'h20; data_size = 2'b10; wd = 32'hBAD0BAD0;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rd", rd, rd_o);
            chk("hold_fault", 32'(fault), 32'(f_o));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("idle_fault", 32'(fault), 32'd0);
        chk("idle_rd_held", rd, f_o ? 32'h0 : rd_o);
    endtask

    task automatic run_check(input logic [31:0] a_i, input logic [31:0] wd_i, input logic [1:0] sz,
                             input logic we_i, input logic uns_i, input int hold,
                             input logic [31:0] exp_rd, input logic exp_f);
        logic [31:0] r;
        logic        f;
        int          lat;
        txn(a_i, wd_i, sz, we_i, uns_i, hold, r, f, lat);
        $display("txn a=%h wd=%h sz=%0d we=%b uns=%b -> rd=%h fault=%b lat=%0d",
                 a_i, wd_i, sz, we_i, uns_i, r, f, lat);
        chk("latency", 32'(lat), 32'd2);
        chk("rd", r, exp_rd);
        chk("fault", 32'(f), 32'(exp_f));
    endtask

    task automatic txn0(input logic [31:0] a_i, input logic [31:0] wd_i, input logic [1:0] sz,
                        input logic we_i, input logic uns_i,
                        input logic [31:0] exp_rd, input logic exp_f);
        int lat;
        @(negedge clk);
        a0 = a_i; wd0 = wd_i; data_size0 = sz; we0 = we_i; data_unsigned0 = uns_i;
        req_valid0 = 1'b1; rsp_ready0 = 1'b0;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        lat = 0;
        while (!rsp_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn0 a=%h wd=%h sz=%0d we=%b -> rd=%h fault=%b lat=%0d",
                 a_i, wd_i, sz, we_i, rd0, fault0, lat);
        chk("w0_latency", 32'(lat), 32'd1);
        chk("w0_rd", rd0, exp_rd);
        chk("w0_fault", 32'(fault0), 32'(exp_f));
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] mr;
        logic        mf;
        int          guard;

        req_valid = 0; a = 0; wd = 0; data_size = 0; we = 0; data_unsigned = 0; rsp_ready = 0;
        req_valid0 = 0; a0 = 0; wd0 = 0; data_size0 = 0; we0 = 0; data_unsigned0 = 0; rsp_ready0 = 0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rd", rd, 32'h0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_req_ready0", 32'(req_ready0), 32'd0);
        rst = 1'b0;

        vecs.push_back('{32'h0,        32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h4,        32'h0,        2'b10, 1'b1, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{32'h8,        32'h0,        2'b10, 1'b1, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{32'h14,       32'hAAAA5555, 2'b10, 1'b1, 1'b0, 32'hAAAA5555, 1'b0});
        vecs.push_back('{32'h20,       32'h11111111, 2'b10, 1'b1, 1'b0, 32'h11111111, 1'b0});
        vecs.push_back('{32'h5,        32'h000000A5, 2'b00, 1'b1, 1'b0, 32'hFFFFFFA5, 1'b0});
        vecs.push_back('{32'h5,        32'h0,        2'b00, 1'b0, 1'b1, 32'h000000A5, 1'b0});
        vecs.push_back('{32'h4,        32'h0,        2'b10, 1'b0, 1'b0, 32'h0000A500, 1'b0});
        vecs.push_back('{32'hA,        32'h00008001, 2'b01, 1'b1, 1'b0, 32'hFFFF8001, 1'b0});
        vecs.push_back('{32'hA,        32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFF8001, 1'b0});
        vecs.push_back('{32'hA,        32'h0,        2'b01, 1'b0, 1'b1, 32'h00008001, 1'b0});
        vecs.push_back('{32'h9,        32'h0000FFFF, 2'b01, 1'b1, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h9,        32'h0,        2'b01, 1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h8,        32'h0,        2'b10, 1'b0, 1'b0, 32'h80010000, 1'b0});
        vecs.push_back('{32'(DEPTH*4), 32'h0,        2'b10, 1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'(DEPTH*4), 32'h55555555, 2'b10, 1'b1, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h2,        32'h77777777, 2'b10, 1'b1, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h0,        32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h7,        32'h00000080, 2'b00, 1'b1, 1'b1, 32'h00000080, 1'b0});
        vecs.push_back('{32'h4,        32'h0,        2'b10, 1'b0, 1'b0, 32'h8000A500, 1'b0});

        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].we, vecs[i].uns, mr, mf);
            run_check(vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].we, vecs[i].uns, 0,
                      vecs[i].exp_rd, vecs[i].exp_f);
        end

        // Response held for 5 cycles with a stray request in the window.
        run_check(32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 5, 32'h11111111, 1'b0);
        run_check(32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 0, 32'h11111111, 1'b0);

        // Reset during WAIT after a committed store; a request under reset is dropped.
        @(negedge clk);
        a = 32'h10; wd = 32'h12345678; data_size = 2'b10; we = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(32'h10, 32'h12345678, 2'b10, 1'b1, 1'b0, mr, mf);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        a = 32'h14; wd = 32'h99999999; data_size = 2'b10; we = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_check(32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 0, 32'h12345678, 1'b0);
        run_check(32'h14, 32'h0, 2'b10, 1'b0, 1'b0, 0, 32'hAAAA5555, 1'b0);

        // Reset while a response is being presented discards it.
        @(negedge clk);
        a = 32'h10; data_size = 2'b10; we = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("pre_rst_rsp_rd", rd, 32'h12345678);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_rd", rd, 32'h0);
        chk("rst_resp_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic over a 16-word window plus occasional out-of-range hits.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            v = $urandom;
            model(32'h40 + 32'(4*i), v, 2'b10, 1'b1, 1'b0, mr, mf);
            run_check(32'h40 + 32'(4*i), v, 2'b10, 1'b1, 1'b0, 0, mr, mf);
        end
        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rw;
            logic [1:0]  rs;
            logic        rwe, ru;
            int          rh;
            ra  = ($urandom_range(0, 15) == 0) ? 32'(DEPTH*4) + 32'($urandom_range(0, 255))
                                               : 32'h40 + 32'($urandom_range(0, 63));
            rs  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rw  = $urandom;
            rwe = 1'($urandom);
            ru  = 1'($urandom);
            rh  = $urandom_range(0, 2);
            model(ra, rw, rs, rwe, ru, mr, mf);
            run_check(ra, rw, rs, rwe, ru, rh, mr, mf);
        end

        // Zero-wait-state build.
        txn0(32'h3C, 32'hCAFEF00D, 2'b10, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
        txn0(32'h3F, 32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFCA, 1'b0);
        txn0(32'h40, 32'h0,        2'b10, 1'b0, 1'b0, 32'h0,        1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  32  byte address.
REQ-008 SHALL have port wd  input  32  write data, low-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port data_size  input  2  access size: 00 byte, 01 half-word, 10 word, 11 illegal.
REQ-010 SHALL have port we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port data_unsigned  input  1  0 = sign-extend, 1 = zero-extend the result.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have port rd  output  32  extended response data.
REQ-015 SHALL have port fault  output  1  request was misaligned, illegal-size or out of range; qualified by rsp_valid.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE goes directly to RESP when WAIT_STATES = 0.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-018 SHALL register a, wd, data_size, we and data_unsigned at acceptance; later input changes have no effect on the in-flight access.
REQ-019 SHALL, in WAIT, count WAIT_STATES cycles, then enter RESP; rsp_valid rises exactly WAIT_STATES+1 edges after the accepting edge.
REQ-020 SHALL hold rsp_valid, rd and fault stable in RESP until an edge with rsp_ready = 1, then return to IDLE (one request outstanding, no overlap).
REQ-021 SHALL decode a fault when data_size = 11, or (half and a[0] = 1), or (word and a[1:0] != 00), or word index a[31:2] >= DEPTH_WORDS.
REQ-022 SHALL, on a faulting request, leave memory unmodified, drive rd = 0 and fault = 1 in RESP.
REQ-023 SHALL, on a valid store, commit the write at the accepting edge using little-endian byte enables (byte lane a[1:0], half lanes a[1]*2..+1, word all lanes).
REQ-024 SHALL return for a store the extended value of the written lanes as they are after the write (read-after-write).
REQ-025 SHALL return for a load the addressed lanes extended to 32 bits per data_unsigned; for a word access data_unsigned is ignored.
REQ-026 SHALL drive fault = 0 and rd unchanged from the last response whenever rsp_valid = 0.

Reset
REQ-027 SHALL, on rst assertion at any time, immediately force state IDLE, wait counter 0, rsp_valid = 0, rd = 0, fault = 0, and req_ready = 0 while rst is high.
REQ-028 SHALL not reset memory contents; a store committed before rst is retained, and an in-flight response is discarded.
REQ-029 SHALL give rst priority over a simultaneous acceptance; no write occurs on that edge.

Structure
REQ-030 SHALL place the data_size encodings, the FSM state encoding and the fault-reason constants in shared package data_memory_pkg.
REQ-031 SHALL use one sub-module, mem_lane_unit, combinational, generating the byte enables and the aligned/extended load data from the address offset, size and data_unsigned.
REQ-032 SHALL implement the storage as a DEPTH_WORDS x 32 array of four byte lanes, with no reset on the array.

Verification
REQ-033 Word store 0xDEADBEEF @0x0, WAIT_STATES=1 -> rsp_valid on the 2nd edge after acceptance, rd=0xDEADBEEF, fault=0; load @0x0 -> 0xDEADBEEF.
REQ-034 Byte store 0x000000A5 @0x5 -> rd=0xFFFFFFA5; unsigned byte load @0x5 -> 0x000000A5; word load @0x4 -> 0x0000A500.
REQ-035 Half store 0x8001 @0xA, signed load -> 0xFFFF8001; unsigned load -> 0x00008001; half load @0x9 -> fault=1, rd=0, memory unchanged.
REQ-036 rsp_ready held low 5 cycles -> rsp_valid/rd stable and req_ready=0 throughout; a req_valid pulse in this window is ignored.
REQ-037 rst asserted in WAIT after a word store 0x12345678 @0x10 -> rsp_valid drops immediately; a later load @0x10 -> 0x12345678.
REQ-038 Word load @ DEPTH_WORDS*4 -> fault=1, rd=0; data_size=11 -> fault=1; WAIT_STATES=0 build -> rsp_valid on the 1st edge after acceptance.
